// File: rtl/user_rom_reader_pkg.sv
// Shared types and defaults for the user-domain ROM reader: FSM state encoding
// and the default timeout/burst-length parameters.
package user_rom_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DefaultTimeoutCycles = 4;
  localparam int unsigned DefaultMaxLen        = 16;

endpackage

// File: rtl/user_rom_reader.sv
// Burst reader for the user ROM accelerator port: fetches len bytes starting at
// base, one request outstanding at a time, accumulating a wrapping sum and XOR.
module user_rom_reader
  import user_rom_reader_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
  parameter int unsigned MaxLen        = DefaultMaxLen,
  localparam int unsigned LenW         = $clog2(MaxLen + 1),
  localparam int unsigned ToW          = $clog2(TimeoutCycles + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     base_addr_i,
  input  logic [LenW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [15:0]     sum_o,
  output logic [7:0]      xor_o,
  output logic            accel_req_o,
  output logic [31:0]     accel_addr_o,
  input  logic [7:0]      accel_data_i,
  input  logic            accel_valid_i
);

  state_e            state_q, state_d;
  logic [31:0]       base_q,  base_d;
  logic [LenW-1:0]   len_q,   len_d;
  logic [LenW-1:0]   cnt_q,   cnt_d;
  logic [ToW-1:0]    to_q,    to_d;
  logic [15:0]       sum_q,   sum_d;
  logic [7:0]        xor_q,   xor_d;
  logic              err_q,   err_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sum_d   = sum_q;
    xor_d   = xor_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          len_d   = (len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : len_i;
          cnt_d   = '0;
          to_d    = '0;
          sum_d   = '0;
          xor_d   = '0;
          err_d   = 1'b0;
          // Clamping never turns a nonzero length into zero, so test the raw input.
          state_d = (len_i != '0) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (accel_valid_i) begin
          sum_d   = sum_q + {8'h00, accel_data_i};
          xor_d   = xor_q ^ accel_data_i;
          cnt_d   = cnt_q + LenW'(1);
          state_d = (({1'b0, cnt_q} + (LenW+1)'(1)) < {1'b0, len_q}) ? ST_REQ : ST_DONE;
        end else if (to_q == ToW'(TimeoutCycles - 1)) begin
          // This idle cycle is the TimeoutCycles-th one: abandon the burst.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the async reset clears every register so an abandoned burst leaves
  // no stale address, length or accumulator behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      sum_q   <= '0;
      xor_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values.
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sum_q   <= sum_d;
      xor_q   <= xor_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;
  assign sum_o        = sum_q;
  assign xor_o        = xor_q;
  assign accel_req_o  = (state_q == ST_REQ);
  // Address bus idles at zero so nothing downstream sees a stale address.
  assign accel_addr_o = accel_req_o ? (base_q + 32'(cnt_q)) : 32'h0;

endmodule

// File: doc/user_rom_reader.md
USER_ROM_READER -- requirements
Module: user_rom_reader

Interface
REQ-001 Parameter TimeoutCycles, default 4: max cycles waited for accel_valid_i per byte before abort.
REQ-002 Parameter MaxLen, default 16: largest accepted burst length in bytes.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 start_i  input  1  start pulse; sampled only in IDLE.
REQ-006 base_addr_i  input  32  byte address of first ROM byte; captured on accepted start.
REQ-007 len_i  input  $clog2(MaxLen+1)  byte count; captured on accepted start.
REQ-008 busy_o  output  1  high from accepted start until done_o cycle inclusive.
REQ-009 done_o  output  1  one-cycle completion pulse.
REQ-010 err_o  output  1  valid with done_o; high = burst aborted on timeout.
REQ-011 sum_o  output  16  wrapping sum of bytes received; held until next accepted start.
REQ-012 xor_o  output  8  XOR of bytes received; held until next accepted start.
REQ-013 accel_req_o  output  1  byte read request to ROM accelerator port.
REQ-014 accel_addr_o  output  32  byte address of current request.
REQ-015 accel_data_i  input  8  returned ROM byte.
REQ-016 accel_valid_i  input  1  accel_data_i valid; ROM asserts it the cycle after a request to an in-range address.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: start_i=1 captures base/len, clears sum/xor/err/byte counter; next state REQ if len>0, else DONE.
REQ-019 len_i > MaxLen is clamped to MaxLen at capture.
REQ-020 REQ: accel_req_o=1 for exactly one cycle, accel_addr_o = base + byte counter (32-bit, wraps modulo 2^32); next state WAIT.
REQ-021 accel_req_o is 0 in every state except REQ; at most one request outstanding.
REQ-022 WAIT: accel_valid_i=1 adds zero-extended accel_data_i to sum (mod 2^16), XORs into xor, increments counter; next REQ if counter+1 < len, else DONE.
REQ-023 WAIT: timeout counter starts at 0 on entry, increments per cycle without valid; at TimeoutCycles, err set, next DONE, no further requests.
REQ-024 accel_valid_i outside WAIT is ignored.
REQ-025 DONE: done_o=1, busy_o=1 for one cycle; next IDLE.
REQ-026 Nominal throughput: 2 cycles per byte; len=N, no errors -> done_o exactly 2N+1 cycles after start accepted (len=0 -> 1 cycle).
REQ-027 start_i while not IDLE is ignored, including in the DONE cycle.
REQ-028 sum_o/xor_o/err_o update only in WAIT/abort and clear only on accepted start.

Reset
REQ-029 rst_ni low: state IDLE; busy_o, done_o, err_o, accel_req_o = 0; accel_addr_o, sum_o, xor_o, counters = 0.
REQ-030 Reset mid-burst abandons the burst immediately, no done_o; a late accel_valid_i after release is ignored (IDLE).

Structure
REQ-031 FSM state enum and default TimeoutCycles belong in the shared user-domain package.
REQ-032 No sub-module required; timeout counter inline.

Verification (bench connects user_rom, contents byte k = k+1 for k=0..15)
REQ-033 base 0, len 4 -> sum_o 0x000A, xor_o 0x04, err_o 0, done_o 9 cycles after start.
REQ-034 base 0, len 16 -> sum_o 0x0088, xor_o 0x10, err_o 0, exactly 16 single-cycle accel_req_o pulses.
REQ-035 base 14, len 4 -> bytes 0x0F, 0x10, then timeout at addr 16: err_o 1, sum_o 0x001F, xor_o 0x1F, no request to addr 17.
REQ-036 len 0 -> done_o next cycle, sum_o 0, no accel_req_o; start_i held high during busy burst -> single burst only.
REQ-037 rst_ni low during WAIT of byte 2 -> all outputs 0 asynchronously; no done_o; next start runs cleanly.
